// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the SRAM request arbiter.
// Requester indices and FSM state encoding.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam int REQ_WEIGHTS = 0;
  localparam int REQ_INPUTS  = 1;
  localparam int REQ_OUT     = 2;

  localparam int DEF_NREQ = 3;
  localparam int DEF_AW   = 10;
  localparam int DEF_DW   = 64;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request
// at or after rr_ptr, wrapping around.
module rr_pick
  import sram_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic            valid,
  output logic [PW-1:0]   idx
);

  logic [PW-1:0] cand;

  // Walk from farthest to nearest so the nearest hit is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = PW'((int'(rr_ptr) + k) % NREQ);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM
// between fetch/writeback requesters, with ack timeout.
module sram_req_arbiter
  import sram_arb_pkg::*;
#(
  parameter int              NREQ    = DEF_NREQ,
  parameter int              AW      = DEF_AW,
  parameter int              DW      = DEF_DW,
  parameter logic [NREQ-1:0] WR_MASK = NREQ'(3'b100),
  parameter int              TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [DW-1:0]    req_wdata,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic [DW-1:0]    rdata,
  output logic             busy,
  output logic             timeout_err,
  input  logic             err_clr,
  output logic             sram_req,
  output logic             sram_we,
  output logic [AW-1:0]    sram_addr,
  output logic [DW-1:0]    sram_wdata,
  input  logic             sram_ack,
  input  logic [DW-1:0]    sram_rdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT);

  state_t        state;
  state_t        state_nx;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] idx_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          we_q;
  logic [CW-1:0] cnt;
  logic [DW-1:0] rdata_q;
  logic          err_q;

  logic          pick_valid;
  logic [PW-1:0] pick_idx;
  logic          load;
  logic          cap;
  logic          to_hit;
  logic          cnt_inc;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  always_comb begin
    state_nx = state;
    gnt      = '0;
    done     = '0;
    sram_req = 1'b0;
    load     = 1'b0;
    cap      = 1'b0;
    to_hit   = 1'b0;
    cnt_inc  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          load     = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        sram_req = 1'b1;
        gnt      = NREQ'(1) << idx_q;
        state_nx = WAIT;
      end
      WAIT: begin
        if (sram_ack) begin
          cap      = 1'b1;
          state_nx = DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          to_hit   = 1'b1;
          state_nx = DONE;
        end else begin
          cnt_inc  = 1'b1;
        end
      end
      DONE: begin
        done     = NREQ'(1) << idx_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        idx_q   <= pick_idx;
        addr_q  <= req_addr[int'(pick_idx)*AW +: AW];
        wdata_q <= req_wdata;
        we_q    <= WR_MASK[pick_idx];
      end
      if (state == ISSUE) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
      if (cap) begin
        rdata_q <= we_q ? '0 : sram_rdata;
      end else if (to_hit) begin
        rdata_q <= '0;
      end
      // A timeout in the same cycle as err_clr keeps the flag set.
      if (to_hit) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
      if (state == DONE) begin
        rr_ptr <= (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
      end
    end
  end

  assign busy        = (state != IDLE);
  assign rdata       = rdata_q;
  assign timeout_err = err_q;
  assign sram_we     = sram_req & we_q;
  assign sram_addr   = sram_req ? addr_q : '0;
  assign sram_wdata  = sram_req ? wdata_q : '0;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Self-checking bench for sram_req_arbiter: directed
// table, corner sequences, randomized transactions.
module tb_sram_req_arbiter;
  import sram_arb_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = 10;
  localparam int DW   = 64;

  logic            clk = 1'b0;
  logic            n_rst;
  logic [NREQ-1:0] req;
  logic [NREQ*AW-1:0] req_addr;
  logic [DW-1:0]   req_wdata;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic            timeout_err;
  logic            err_clr;
  logic            sram_req;
  logic            sram_we;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_wdata;
  logic            sram_ack;
  logic [DW-1:0]   sram_rdata;

  sram_req_arbiter dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .req         (req),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .gnt         (gnt),
    .done        (done),
    .rdata       (rdata),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr),
    .sram_req    (sram_req),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_ack    (sram_ack),
    .sram_rdata  (sram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  r;
    logic [9:0]  a0;
    logic [9:0]  a1;
    logic [9:0]  a2;
    logic [63:0] wd;
    int          d;
    logic [63:0] ad;
    int          e_idx;
    bit          e_we;
    logic [9:0]  e_addr;
    logic [63:0] e_rdata;
    bit          e_to;
  } vec_t;

  vec_t tbl[9];
  int   vectors = 0;
  int   miscompares = 0;
  bit   exp_err = 1'b0;
  bit   set_pend = 1'b0;
  bit   clr_en = 1'b0;
  int   ptr = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic c;
    c = err_clr;
    @(negedge clk);
    if (c) exp_err = 1'b0;
    if (set_pend) exp_err = 1'b1;
    set_pend = 1'b0;
    chk("timeout_err", 64'(timeout_err), 64'(exp_err));
    if (clr_en) err_clr = ($urandom % 6 == 0);
  endtask

  function automatic int pick(input logic [2:0] r, input int p);
    int best = -1;
    int bd = 4;
    for (int i = 0; i < 3; i++) begin
      if (r[i]) begin
        int dd = (i - p + 3) % 3;
        if (dd < bd) begin
          bd = dd;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic run_txn(input vec_t v, input bit drop, input bit spur);
    logic [2:0] oh;
    int ec;
    oh = 3'(1) << v.e_idx;
    req = v.r;
    req_addr = {v.a2, v.a1, v.a0};
    req_wdata = v.wd;
    tick();
    chk("gnt", 64'(gnt), 64'(oh));
    chk("sram_req", 64'(sram_req), 64'(1));
    chk("sram_we", 64'(sram_we), 64'(v.e_we));
    chk("sram_addr", 64'(sram_addr), 64'(v.e_addr));
    if (v.e_we) chk("sram_wdata", sram_wdata, v.wd);
    chk("busy_issue", 64'(busy), 64'(1));
    if (drop) req = '0;
    ec = (v.d <= 32) ? v.d + 1 : 33;
    for (int c = 1; c <= ec; c++) begin
      sram_ack = (c - 1 == v.d) || (c == 1 && spur);
      sram_rdata = (c - 1 == v.d) ? v.ad : {$urandom, $urandom};
      if (c == ec) set_pend = v.e_to;
      tick();
      chk("done", 64'(done), 64'((c == ec) ? oh : 3'b000));
      chk("busy_txn", 64'(busy), 64'(1));
      if (c == ec) chk("rdata", rdata, v.e_rdata);
    end
    sram_ack = spur;
    sram_rdata = {$urandom, $urandom};
    tick();
    chk("busy_idle", 64'(busy), 64'(0));
    chk("done_idle", 64'(done), 64'(0));
    chk("rdata_hold", rdata, v.e_rdata);
    sram_ack = 1'b0;
    req = '0;
    ptr = (v.e_idx + 1) % 3;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    n_rst = 1'b0;
    req = '0;
    req_addr = '0;
    req_wdata = '0;
    err_clr = 1'b0;
    sram_ack = 1'b0;
    sram_rdata = '0;

    for (int i = 0; i < 6; i++) begin
      tbl[i].r = 3'b111;
      tbl[i].a0 = 10'h011;
      tbl[i].a1 = 10'h122;
      tbl[i].a2 = 10'h233;
      tbl[i].wd = 64'h55;
      tbl[i].d = 8;
      tbl[i].ad = 64'hC0DE_0000 + 64'(i);
      tbl[i].e_idx = i % 3;
      tbl[i].e_we = (i % 3 == 2);
      tbl[i].e_addr = (i % 3 == 0) ? 10'h011 :
                      (i % 3 == 1) ? 10'h122 : 10'h233;
      tbl[i].e_rdata = (i % 3 == 2) ? 64'h0 : 64'hC0DE_0000 + 64'(i);
      tbl[i].e_to = 1'b0;
    end
    tbl[6] = '{3'b001, 10'h010, 10'h0, 10'h0, 64'h0, 8,
               64'hAAAA0000_BBBB0000, 0, 1'b0, 10'h010,
               64'hAAAA0000_BBBB0000, 1'b0};
    tbl[7] = '{3'b100, 10'h0, 10'h0, 10'h3FF, 64'h1234, 8,
               64'hDEAD, 2, 1'b1, 10'h3FF, 64'h0, 1'b0};
    tbl[8] = '{3'b010, 10'h0, 10'h0AB, 10'h0, 64'h0, 40,
               64'hBEEF, 1, 1'b0, 10'h0AB, 64'h0, 1'b1};

    tick();
    tick();
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_sram_req", 64'(sram_req), 64'(0));
    chk("rst_sram_we", 64'(sram_we), 64'(0));
    chk("rst_sram_addr", 64'(sram_addr), 64'(0));
    chk("rst_sram_wdata", sram_wdata, 64'h0);
    n_rst = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_txn(tbl[i], 1'b0, 1'b0);

    tick();
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    tick();

    req = 3'b010;
    req_addr = {10'h0, 10'h155, 10'h0};
    tick();
    chk("rstw_gnt", 64'(gnt), 64'(3'b010));
    req = '0;
    tick();
    chk("rstw_busy", 64'(busy), 64'(1));
    #1;
    n_rst = 1'b0;
    exp_err = 1'b0;
    #1;
    chk("rstw_busy0", 64'(busy), 64'(0));
    chk("rstw_sram_req", 64'(sram_req), 64'(0));
    tick();
    n_rst = 1'b1;
    sram_ack = 1'b1;
    sram_rdata = 64'h1111_2222;
    tick();
    sram_ack = 1'b0;
    chk("rstw_done", 64'(done), 64'(0));
    chk("rstw_busy1", 64'(busy), 64'(0));
    tick();
    chk("rstw_done2", 64'(done), 64'(0));
    chk("rstw_busy2", 64'(busy), 64'(0));
    ptr = 0;

    v = '{3'b110, 10'h0, 10'h2AA, 10'h3C3, 64'h77, 3,
          64'h5A5A, 1, 1'b0, 10'h2AA, 64'h5A5A, 1'b0};
    run_txn(v, 1'b0, 1'b0);

    clr_en = 1'b1;
    for (int n = 0; n < 250; n++) begin
      logic [2:0] r;
      r = 3'($urandom);
      if (r == 3'b000) begin
        req = '0;
        tick();
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_gnt", 64'(gnt), 64'(0));
        continue;
      end
      v.r = r;
      v.a0 = 10'($urandom);
      v.a1 = 10'($urandom);
      v.a2 = 10'($urandom);
      v.wd = {$urandom, $urandom};
      v.ad = {$urandom, $urandom};
      v.d = ($urandom % 10 == 0) ? 33 + int'($urandom % 4) :
            ($urandom % 9 == 0) ? 32 : 1 + int'($urandom % 12);
      v.e_idx = pick(r, ptr);
      v.e_we = (v.e_idx == REQ_OUT);
      v.e_addr = (v.e_idx == 0) ? v.a0 : (v.e_idx == 1) ? v.a1 : v.a2;
      v.e_to = (v.d > 32);
      v.e_rdata = (v.e_to || v.e_we) ? 64'h0 : v.ad;
      run_txn(v, ($urandom % 4 == 0), ($urandom % 3 == 0));
    end
    clr_en = 1'b0;
    err_clr = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
